spi_burst_reader: RTL and testbench
===================================

SPI_BURST_READER -- requirements
Module: spi_burst_reader

Interface
REQ-001 Parameter WORDBITS, default 8, SPI word width; SHALL match the attached SPI master.
REQ-002 Parameter MAX_BURST, default 16, maximum data words per burst.
REQ-003 Parameter TIMEOUT_CLKS, default 4096, clocks allowed per word before abort.
REQ-004 Localparam LW = $clog2(MAX_BURST+1); localparam IW = $clog2(MAX_BURST).
REQ-005 clock  in  1  sole clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 start  in  1  request a burst; sampled only in IDLE.
REQ-008 regAddr  in  WORDBITS-1  device register address.
REQ-009 readLen  in  LW  number of data words to read, 0..MAX_BURST.
REQ-010 busy  out  1  high from first cycle after accepted start until done.
REQ-011 done  out  1  one-cycle pulse at burst end (normal or abort).
REQ-012 error  out  1  set with done on timeout or readLen>MAX_BURST; held until next accepted start.
REQ-013 rxWord  out  WORDBITS  received data word.
REQ-014 rxValid  out  1  one-cycle pulse, rxWord/rxIndex valid.
REQ-015 rxIndex  out  IW  position of rxWord in burst, 0-based.
REQ-016 spiTxData  out  WORDBITS  word to SPI master.
REQ-017 spiSend  out  1  transfer request to SPI master, level.
REQ-018 spiRxData  in  WORDBITS  word received by SPI master.
REQ-019 spiComplete  in  1  one-cycle completion pulse from SPI master.

Function
REQ-020 States: IDLE, ADDR_XFER, ADDR_GAP, DATA_XFER, DATA_GAP, FINISH; all registered outputs.
REQ-021 IDLE: start=1 and 1<=readLen<=MAX_BURST -> latch readLen, spiTxData={1'b1,regAddr}, spiSend=1, busy=1, error=0, go ADDR_XFER next edge.
REQ-022 IDLE: start=1, readLen=0 -> done=1 next cycle, error=0, no SPI activity, stay IDLE.
REQ-023 IDLE: start=1, readLen>MAX_BURST -> done=1, error=1 next cycle, no SPI activity.
REQ-024 start while busy SHALL be ignored.
REQ-025 ADDR_XFER: hold spiSend=1 and spiTxData until spiComplete=1; then spiSend=0, discard spiRxData, go ADDR_GAP.
REQ-026 GAP states: spiSend held 0 for exactly 2 cycles (lets master leave its restart state), then spiTxData=0, spiSend=1, go DATA_XFER.
REQ-027 DATA_XFER on spiComplete=1: rxWord=spiRxData, rxIndex=word counter, rxValid=1 for one cycle, spiSend=0, counter+1.
REQ-028 After last word (counter==latched readLen-1) go FINISH, else DATA_GAP.
REQ-029 FINISH: done=1 one cycle, busy=0, return IDLE; next start accepted the following cycle.
REQ-030 Timeout counter cleared at every spiSend rising edge; incremented each XFER cycle; reaching TIMEOUT_CLKS-1 without spiComplete -> spiSend=0, done=1, error=1, busy=0, IDLE.
REQ-031 spiComplete outside XFER states SHALL be ignored.
REQ-032 spiTxData SHALL be stable for the whole time spiSend=1.
REQ-033 Word counter width LW; never exceeds latched readLen; no wrap.
REQ-034 Minimum burst latency: start to done = sum of SPI word times + 3 cycles per word + 2.

Reset
REQ-035 reset=1 SHALL, at the next edge and from any state, force IDLE, spiSend=0, spiTxData=0, busy=0, done=0, error=0, rxValid=0, rxWord=0, rxIndex=0, counters=0.
REQ-036 reset mid-transfer SHALL NOT emit done or rxValid; spiSend low for at least 2 cycles after release before any new transfer.

Verification
REQ-037 regAddr=0x3B, readLen=3, SPI model returns 0xAA,0x11,0x22,0x33 -> tx sequence 0xBB,0x00,0x00,0x00; rxValid x3 with (0,0x11),(1,0x22),(2,0x33); one done, error=0.
REQ-038 readLen=0 -> done pulse next cycle, spiSend never high; readLen=17 (MAX_BURST=16) -> done and error=1, spiSend never high.
REQ-039 Model withholds spiComplete on word 2 -> after TIMEOUT_CLKS cycles spiSend=0, done=1, error=1; only index 0 delivered.
REQ-040 start pulsed during active burst -> ignored; burst completes unchanged; back-to-back start in cycle after done accepted.
REQ-041 reset asserted during DATA_XFER word 1 -> next cycle all outputs zero, no done; new burst after reset completes correctly.
REQ-042 Every transfer: spiSend low >=2 cycles between words; spiTxData constant while spiSend=1 (assertion).

Source files
------------

// File: rtl/spi_burst_reader.sv
// spi_burst_reader: reads a burst of device registers through an attached
// SPI word master. It sends one address word with the read flag in the MSB,
// then clocks out zero words and returns each received word together with
// its position in the burst.
module spi_burst_reader #(
    parameter int WORDBITS     = 8,
    parameter int MAX_BURST    = 16,
    parameter int TIMEOUT_CLKS = 4096,
    localparam int LW = $clog2(MAX_BURST + 1),
    localparam int IW = $clog2(MAX_BURST)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [WORDBITS-2:0] regAddr,
    input  logic [LW-1:0]       readLen,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [WORDBITS-1:0] rxWord,
    output logic                rxValid,
    output logic [IW-1:0]       rxIndex,
    output logic [WORDBITS-1:0] spiTxData,
    output logic                spiSend,
    input  logic [WORDBITS-1:0] spiRxData,
    input  logic                spiComplete
);

    localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [LW-1:0] MAX_L    = LW'(MAX_BURST);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_XFER,
        ADDR_GAP,
        DATA_XFER,
        DATA_GAP,
        FINISH
    } state_t;

    state_t                state_q, state_d;
    logic                  send_q, send_d;
    logic [WORDBITS-1:0]   tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  rxv_q, rxv_d;
    logic [WORDBITS-1:0]   rxw_q, rxw_d;
    logic [IW-1:0]         rxi_q, rxi_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  gap_q, gap_d;
    // Settle timer after reset: keeps the master idle for two cycles so it
    // can leave its own restart state before the first new transfer.
    logic [1:0]            quiet_q, quiet_d;

    // State and output registers; reset forces every output and counter low.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            send_q  <= 1'b0;
            tx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rxv_q   <= 1'b0;
            rxw_q   <= '0;
            rxi_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            gap_q   <= 1'b0;
            quiet_q <= 2'd2;
        end else begin
            state_q <= state_d;
            send_q  <= send_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rxv_q   <= rxv_d;
            rxw_q   <= rxw_d;
            rxi_q   <= rxi_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            quiet_q <= quiet_d;
        end
    end

    // Next-state and next-output logic; done/rxValid are single-cycle pulses.
    always_comb begin
        state_d = state_q;
        send_d  = send_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        rxv_d   = 1'b0;
        rxw_d   = rxw_q;
        rxi_d   = rxi_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        quiet_d = quiet_q;

        case (state_q)
            IDLE: begin
                if (quiet_q != 2'd0) begin
                    quiet_d = quiet_q - 2'd1;
                end else if (start) begin
                    if (readLen == '0) begin
                        done_d = 1'b1;
                        err_d  = 1'b0;
                    end else if (readLen > MAX_L) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        len_d   = readLen;
                        cnt_d   = '0;
                        tx_d    = {1'b1, regAddr};
                        send_d  = 1'b1;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        tmo_d   = '0;
                        state_d = ADDR_XFER;
                    end
                end
            end

            ADDR_XFER, DATA_XFER: begin
                if (spiComplete) begin
                    send_d = 1'b0;
                    gap_d  = 1'b0;
                    if (state_q == ADDR_XFER) begin
                        // The word clocked in during the address phase is junk.
                        state_d = ADDR_GAP;
                    end else begin
                        rxw_d   = spiRxData;
                        rxi_d   = cnt_q[IW-1:0];
                        rxv_d   = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = (cnt_q == len_q - 1'b1) ? FINISH : DATA_GAP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    send_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ADDR_GAP, DATA_GAP: begin
                if (!gap_q) begin
                    gap_d = 1'b1;
                end else begin
                    tx_d    = '0;
                    send_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = DATA_XFER;
                end
            end

            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = err_q;
    assign rxWord    = rxw_q;
    assign rxValid   = rxv_q;
    assign rxIndex   = rxi_q;
    assign spiTxData = tx_q;
    assign spiSend   = send_q;

endmodule

// File: tb/tb_spi_burst_reader.sv
// Self-checking bench for spi_burst_reader: a randomized SPI word-master
// model answers transfers, a transaction-level model predicts the tx words,
// received words and done/error outcome of every burst, and one monitor
// compares the DUT against it on every cycle.
module tb_spi_burst_reader;

    localparam int WB = 8;
    localparam int MB = 16;
    localparam int TO = 24;
    localparam int LW = $clog2(MB + 1);
    localparam int IW = $clog2(MB);

    logic          clock, reset, start;
    logic [WB-2:0] regAddr;
    logic [LW-1:0] readLen;
    logic          busy, done, error, rxValid, spiSend, spiComplete;
    logic [WB-1:0] rxWord, spiTxData, spiRxData;
    logic [IW-1:0] rxIndex;

    spi_burst_reader #(.WORDBITS(WB), .MAX_BURST(MB), .TIMEOUT_CLKS(TO)) dut (
        .clock(clock), .reset(reset), .start(start), .regAddr(regAddr),
        .readLen(readLen), .busy(busy), .done(done), .error(error),
        .rxWord(rxWord), .rxValid(rxValid), .rxIndex(rxIndex),
        .spiTxData(spiTxData), .spiSend(spiSend), .spiRxData(spiRxData),
        .spiComplete(spiComplete)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { int idx; logic [7:0] w; } rx_t;

    int checks = 0, errors = 0;
    logic [7:0] rxq[$];      // words the SPI model returns, per transfer
    logic [7:0] exp_tx[$];
    rx_t        exp_rx[$];
    logic [7:0] tx_log[$];
    rx_t        rx_log[$];
    int  pend = 0;
    bit  exp_err = 0;
    int  wh = -1;            // transfer number the SPI model never completes
    bit  mute = 0;
    int  xfer_cnt = 0;
    int  last_hi = 0;
    int  done_seen = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // tx word must stay put while a transfer is requested
    a_tx_stable: assert property (@(posedge clock) disable iff (reset)
        (spiSend && $past(spiSend)) |-> (spiTxData == $past(spiTxData)));

    // SPI master model: completes each transfer after 1..4 cycles of spiSend,
    // and sprinkles stray completion pulses while spiSend is low.
    initial begin
        automatic bit act = 0, fin = 0;
        automatic int hi = 0, d = 1, id = 0;
        spiComplete = 1'b0;
        spiRxData   = '0;
        forever begin
            @(posedge clock); #1;
            spiComplete = 1'b0;
            if (reset) begin
                act = 0; fin = 0; hi = 0;
            end else if (spiSend) begin
                if (!act) begin
                    act = 1; fin = 0; hi = 0;
                    d = $urandom_range(1, 4);
                    id = xfer_cnt;
                    xfer_cnt++;
                end
                hi++;
                if (!fin && hi == d && id != wh && !mute) begin
                    spiComplete = 1'b1;
                    spiRxData   = (id < rxq.size()) ? rxq[id] : 8'hEE;
                    fin = 1;
                end
            end else begin
                act = 0; fin = 0;
                if ($urandom_range(0, 7) == 0) begin
                    spiComplete = 1'b1;
                    spiRxData   = 8'($urandom);
                end
            end
        end
    end

    // Compare process: every cycle, just after the active edge.
    initial begin
        automatic bit prev = 0;
        automatic int low_run = 0, hi_run = 0;
        automatic logic [7:0] e;
        automatic rx_t r;
        forever begin
            @(posedge clock); #1;
            if (reset) begin
                low_run = 0; hi_run = 0; prev = 0;
            end else begin
                if (spiSend && !prev) begin
                    chk("gap_low_ge2", int'(low_run >= 2), 1);
                    tx_log.push_back(spiTxData);
                    if (exp_tx.size() == 0) chk("tx_unexpected", int'(spiTxData), -1);
                    else begin
                        e = exp_tx.pop_front();
                        chk("tx_word", int'(spiTxData), int'(e));
                    end
                    hi_run = 0;
                end
                if (spiSend) begin
                    hi_run++;
                    low_run = 0;
                    chk("busy_during_xfer", int'(busy), 1);
                end else begin
                    if (prev) last_hi = hi_run;
                    low_run++;
                end
                if (rxValid) begin
                    r.idx = int'(rxIndex); r.w = rxWord;
                    rx_log.push_back(r);
                    if (exp_rx.size() == 0) chk("rx_unexpected", int'(rxIndex), -1);
                    else begin
                        r = exp_rx.pop_front();
                        chk("rx_index", int'(rxIndex), r.idx);
                        chk("rx_word", int'(rxWord), int'(r.w));
                    end
                end
                if (done) begin
                    done_seen++;
                    if (pend == 0) chk("done_unexpected", 1, 0);
                    else begin
                        chk("done_error", int'(error), int'(exp_err));
                        chk("done_busy", int'(busy), 0);
                        pend--;
                    end
                end
                if (!busy && pend == 0) chk("error_hold", int'(error), int'(exp_err));
                prev = spiSend;
            end
        end
    end

    // One burst: build expectations, raise start until accepted, wait done.
    task automatic run_burst(input int addr, input int len, input int whi,
                             input bit fixed, input bit inject, output int lat);
        automatic bit valid = (len >= 1 && len <= MB);
        automatic int ntx, nrx, t;
        automatic int d0 = done_seen;
        automatic rx_t r;
        if (!fixed) begin
            rxq.delete();
            for (int i = 0; i <= len; i++) rxq.push_back(8'($urandom));
        end
        xfer_cnt = 0;
        wh = whi;
        exp_tx.delete(); exp_rx.delete();
        if (valid) begin
            ntx = (whi < 0) ? len + 1 : whi + 1;
            nrx = (whi < 0) ? len : whi - 1;
            exp_tx.push_back({1'b1, 7'(addr)});
            for (int i = 1; i < ntx; i++) exp_tx.push_back(8'h00);
            for (int i = 0; i < nrx; i++) begin
                r.idx = i; r.w = rxq[i + 1];
                exp_rx.push_back(r);
            end
        end
        exp_err = (len > MB) || (valid && whi >= 0);
        pend = 1;
        regAddr = 7'(addr);
        readLen = LW'(len);
        start = 1'b1;
        t = 0;
        do begin
            @(negedge clock); t++;
        end while (!(busy || done) && t < 20);
        lat = t;
        start = 1'b0;
        t = 0;
        while (!done && t < 3000) begin
            @(negedge clock); t++;
            if (inject && !done && $urandom_range(0, 2) == 0) begin
                start   = 1'($urandom);
                regAddr = 7'($urandom);
                readLen = LW'($urandom);
            end else start = 1'b0;
        end
        start = 1'b0;
        chk("done_seen_in_time", int'(done), 1);
        chk("done_once", done_seen - d0, 1);
        chk("rx_all_delivered", exp_rx.size(), 0);
        chk("tx_all_sent", exp_tx.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        automatic int lat;
        start = 0; regAddr = '0; readLen = '0; reset = 1'b1;
        idle(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_send", int'(spiSend), 0);
        chk("rst_tx", int'(spiTxData), 0);
        chk("rst_rxvalid", int'(rxValid), 0);
        chk("rst_rxword", int'(rxWord), 0);
        chk("rst_rxindex", int'(rxIndex), 0);
        reset = 1'b0;

        // Fixed pattern: address 0x3B, three data words.
        rxq.delete();
        rxq.push_back(8'hAA); rxq.push_back(8'h11);
        rxq.push_back(8'h22); rxq.push_back(8'h33);
        tx_log.delete(); rx_log.delete();
        run_burst(8'h3B, 3, -1, 1, 0, lat);
        chk("lit_tx_count", tx_log.size(), 4);
        if (tx_log.size() == 4) begin
            chk("lit_tx0", int'(tx_log[0]), 8'hBB);
            chk("lit_tx1", int'(tx_log[1]), 0);
            chk("lit_tx3", int'(tx_log[3]), 0);
        end
        chk("lit_rx_count", rx_log.size(), 3);
        if (rx_log.size() == 3) begin
            chk("lit_rx0", rx_log[0].idx * 256 + int'(rx_log[0].w), 16'h0011);
            chk("lit_rx1", rx_log[1].idx * 256 + int'(rx_log[1].w), 16'h0122);
            chk("lit_rx2", rx_log[2].idx * 256 + int'(rx_log[2].w), 16'h0233);
        end
        chk("lit_error", int'(error), 0);
        idle(2);

        // Zero length and oversize length: immediate done, no SPI traffic.
        tx_log.delete();
        run_burst(8'h05, 0, -1, 0, 0, lat);
        chk("len0_latency", lat, 1);
        chk("len0_error", int'(error), 0);
        idle(1);
        run_burst(8'h06, 17, -1, 0, 0, lat);
        chk("len17_latency", lat, 1);
        chk("len17_error", int'(error), 1);
        chk("invalid_no_spi", tx_log.size(), 0);
        idle(2);

        // Timeout: transfer 2 (second data word) is never completed.
        rx_log.delete();
        run_burst(8'h21, 5, 2, 0, 0, lat);
        chk("timeout_send_cycles", last_hi, TO);
        chk("timeout_rx_count", rx_log.size(), 1);
        chk("timeout_error", int'(error), 1);
        wh = -1;
        idle(2);

        // Starts during a burst are ignored; back-to-back start after done.
        run_burst(8'h44, 6, -1, 0, 1, lat);
        run_burst(8'h45, 2, -1, 0, 0, lat);
        chk("b2b_accept_latency", lat, 1);
        run_burst(8'h46, MB, -1, 0, 1, lat);
        idle(1);

        // Reset during the second data word.
        begin
            automatic int t = 0;
            rx_log.delete();
            rxq.delete();
            for (int i = 0; i <= 6; i++) rxq.push_back(8'($urandom));
            xfer_cnt = 0; wh = -1;
            exp_tx.delete(); exp_rx.delete();
            exp_tx.push_back({1'b1, 7'h12});
            for (int i = 0; i < 6; i++) exp_tx.push_back(8'h00);
            for (int i = 0; i < 6; i++) begin
                automatic rx_t r;
                r.idx = i; r.w = rxq[i + 1];
                exp_rx.push_back(r);
            end
            exp_err = 0; pend = 1;
            regAddr = 7'h12; readLen = LW'(6); start = 1'b1;
            while (!(rx_log.size() >= 1 && spiSend) && t < 500) begin
                @(negedge clock); t++;
                if (busy) start = 1'b0;
            end
            start = 1'b0;
            chk("reached_word1", int'(rx_log.size() >= 1 && spiSend), 1);
            mute = 1; reset = 1'b1;
            exp_tx.delete(); exp_rx.delete(); pend = 0; exp_err = 0;
            @(negedge clock);
            chk("midrst_outputs",
                int'({busy, done, error, rxValid, rxWord, rxIndex, spiTxData, spiSend}), 0);
            reset = 1'b0; mute = 0;
            run_burst(8'h13, 4, -1, 0, 0, lat);
            chk("post_reset_error", int'(error), 0);
        end
        idle(2);

        // Randomized bursts, some invalid, some back-to-back, some injected.
        for (int n = 0; n < 30; n++) begin
            automatic int k = $urandom_range(0, 9);
            automatic int len = (k == 0) ? 0 : (k == 1) ? $urandom_range(17, 31)
                                                        : $urandom_range(1, MB);
            run_burst(int'($urandom_range(0, 127)), len, -1, 0, $urandom_range(0, 1), lat);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(5);
        chk("final_done_count_pending", pend, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
